// File: rtl/lifo_cmd_ctrl.sv
// Command front-end for a 16-deep byte stack: valid/ready push/pop in, popped bytes out,
// with a shadow occupancy count and a sticky cross-check fault against the stack's flags.
module lifo_cmd_ctrl #(
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic              cmd_op,
  input  logic [7:0]        cmd_data,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic              lifo_push,
  output logic              lifo_pop,
  output logic [7:0]        lifo_din,
  input  logic [7:0]        lifo_dout,
  input  logic              lifo_full,
  input  logic              lifo_empty,
  input  logic              lifo_error,
  output logic [CNT_W-1:0]  count,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              fault
);

  typedef enum logic [1:0] {IDLE, POP_ISSUE, POP_CAP, RSP} state_t;

  localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [DROP_W-1:0] r_drop;
  logic              r_fault;
  logic              r_push;
  logic              r_pop;
  logic [7:0]        r_din;
  logic              r_rsp_valid;
  logic [7:0]        r_rsp_data;
  logic              r_rsp_err;

  logic w_ready;
  logic w_accept;
  logic w_flag_bad;

  assign w_ready  = (r_state == IDLE) && !r_fault;
  assign w_accept = cmd_valid && w_ready;

  // Stack flags lag a strobe by one cycle, so they are only compared while both strobes are low.
  assign w_flag_bad = lifo_error ||
                      (!r_push && !r_pop &&
                       ((lifo_empty != (r_count == '0)) || (lifo_full != (r_count == L_DEPTH))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_drop      <= '0;
      r_fault     <= 1'b0;
      r_push      <= 1'b0;
      r_pop       <= 1'b0;
      r_din       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_pop  <= 1'b0;
      if (w_flag_bad) begin
        r_fault <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!cmd_op) begin
              if (r_count != L_DEPTH) begin
                r_push  <= 1'b1;
                r_din   <= cmd_data;
                r_count <= r_count + 1'b1;
              end else if (r_drop != '1) begin
                r_drop <= r_drop + 1'b1;
              end
            end else begin
              if (r_count != '0) begin
                r_pop   <= 1'b1;
                r_count <= r_count - 1'b1;
                r_state <= POP_ISSUE;
              end else begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_data  <= 8'h00;
                r_state     <= RSP;
              end
            end
          end
        end
        POP_ISSUE: begin
          r_state <= POP_CAP;
        end
        POP_CAP: begin
          r_rsp_data  <= lifo_dout;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign lifo_push = r_push;
  assign lifo_pop  = r_pop;
  assign lifo_din  = r_din;
  assign count     = r_count;
  assign drop_cnt  = r_drop;
  assign fault     = r_fault;

endmodule

// File: doc/lifo_cmd_ctrl.md
Name: lifo_cmd_ctrl

Overview:
- Command front-end that sits directly upstream of the 16-deep byte stack and drives its push/pop/data_in pins.
- Accepts push/pop commands on a valid/ready interface and returns popped bytes on a valid/ready response interface.
- Keeps a shadow occupancy count so the stack never receives an illegal or simultaneous push+pop.
- Cross-checks the stack's full/empty/error flags and latches a sticky fault on any mismatch.

Parameters:
- DEPTH, 16, stack depth; must match the downstream stack.
- CNT_W, 5, occupancy counter width (holds 0..DEPTH).
- DROP_W, 8, width of the saturating dropped-push counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_op  in  1  0 = push, 1 = pop.
- cmd_data  in  8  push payload (ignored for pop).
- cmd_ready  out  1  command accepted when valid&ready.
- rsp_valid  out  1  response present.
- rsp_data  out  8  popped byte (0x00 on error).
- rsp_err  out  1  response is an underflow reject.
- rsp_ready  in  1  response consumed when valid&ready.
- lifo_push  out  1  registered push strobe to stack.
- lifo_pop  out  1  registered pop strobe to stack.
- lifo_din  out  8  registered push data to stack.
- lifo_dout  in  8  stack data_out (registered inside stack).
- lifo_full  in  1  stack full flag.
- lifo_empty  in  1  stack empty flag.
- lifo_error  in  1  stack error pulse.
- count  out  CNT_W  shadow occupancy.
- drop_cnt  out  DROP_W  pushes dropped while full (saturating).
- fault  out  1  sticky consistency/error fault.

Behaviour:
- Reset (rst_n low, async): state=IDLE; all outputs 0; count=0; drop_cnt=0; fault=0. Reset mid-pop abandons the transaction. No response is emitted, and the stack must be reset together with this block.
- States: IDLE, POP_ISSUE, POP_CAP, RSP.
- cmd_ready = (state==IDLE) & !fault.
- lifo_push and lifo_pop are mutually exclusive and each is high for exactly one cycle per issued operation.
- IDLE, push accepted, count<DEPTH: lifo_push<=1, lifo_din<=cmd_data, count<=count+1. Remain IDLE.
  - Back-to-back pushes run at 1 per cycle; count, not lifo_full, gates issue.
- IDLE, push accepted, count==DEPTH: no stack op; drop_cnt<=drop_cnt+1, saturating at all-ones. No response.
- IDLE, pop accepted, count>0: lifo_pop<=1, count<=count-1, state<=POP_ISSUE.
- IDLE, pop accepted, count==0: no stack op; rsp_valid<=1, rsp_err<=1, rsp_data<=0x00, state<=RSP.
- POP_ISSUE (lifo_pop high): lifo_pop<=0, state<=POP_CAP.
- POP_CAP: rsp_data<=lifo_dout, rsp_err<=0, rsp_valid<=1, state<=RSP.
- RSP: hold rsp_valid/rsp_data/rsp_err stable until rsp_ready. On handshake rsp_valid<=0, state<=IDLE. The next command can be accepted one cycle later.
- Pop latency: accept edge at cycle N -> rsp_valid high from cycle N+3. The response is valid the same cycle rsp_ready may complete it.
- Strobe defaults: when not issuing, lifo_push<=0 and lifo_pop<=0. lifo_din holds its last value.
- Consistency check, active only in cycles where lifo_push==0 and lifo_pop==0:
  - lifo_empty must equal (count==0).
  - lifo_full must equal (count==DEPTH).
  - Any mismatch, or lifo_error==1 in any cycle, sets fault<=1.
- fault is sticky until reset. While fault=1: cmd_ready=0, no new strobes. A pending response still completes.
- Arithmetic: count never wraps. drop_cnt saturates.

Test Plan:
- Reset, then push 0x11,0x22,0x33 on consecutive cycles -> lifo_push high 3 consecutive cycles with lifo_din 0x11/0x22/0x33; count=3; fault=0.
- Then pop with rsp_ready=1 -> rsp_valid at accept+3 with rsp_data=0x33, rsp_err=0, count=2. Second pop returns 0x22.
- From reset, pop -> rsp_valid at accept+1, rsp_err=1, rsp_data=0x00; no lifo_pop pulse; count stays 0.
- Push 16 bytes, then push 0xAA and 0xBB -> count=16, drop_cnt=2, no extra lifo_push, lifo_full=1, fault=0. A following pop returns the 16th byte.
- Pop with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable and cmd_ready=0 throughout. The handshake on cycle 6 returns to IDLE.
- Force lifo_error=1 for one cycle (or lifo_empty=0 with count=0) -> fault=1 and cmd_ready=0 until rst_n pulse. Asserting rst_n low mid-POP_CAP clears all outputs immediately.
